// File: rtl/cnn_bn_relu_stream_pkg.sv
// Shared constants and helpers for the batch-norm + ReLU stream stage.
// Holds the FSM state encoding and the counter-width helper used by the
// top level and the parameter RAM.
package cnn_bn_relu_stream_pkg;

    // FSM state encoding kept as plain constants for compatibility with older tools.
    localparam logic [1:0] ST_EMPTY = 2'd0;   // no parameters held
    localparam logic [1:0] ST_LOAD  = 2'd1;   // parameter words arriving
    localparam logic [1:0] ST_RUN   = 2'd2;   // parameters complete, pixels accepted

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_bn_relu_stream_param_ram.sv
// Parameter store for the batch-norm stage.
// Two banks split by the write address LSB: bank 0 holds scale[c] (even
// addresses) and bank 1 holds bias[c] (odd addresses). One channel index reads
// both banks at once with a single cycle of latency.
module cnn_bn_param_ram
    import cnn_bn_relu_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CH_NUM     = 1,
    localparam int AW        = cnt_width(2 * CH_NUM),
    localparam int CW        = cnt_width(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [CW-1:0]         rd_ch,
    output logic [DATA_WIDTH-1:0] rd_scale,
    output logic [DATA_WIDTH-1:0] rd_bias
);

    logic [AW-1:0] wr_word;
    logic [CW-1:0] wr_ch;

    // Channel index of the written word is the address with its bank bit removed.
    assign wr_word = wr_addr >> 1;
    assign wr_ch   = wr_word[CW-1:0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [CH_NUM];
        logic [DATA_WIDTH-1:0] rd_q;

        // Bank write when the address LSB selects this bank; registered read every cycle.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_addr[0] == 1'(gi))) begin
                mem[wr_ch] <= wr_data;
            end
            rd_q <= mem[rd_ch];
        end
    end

    assign rd_scale = g_bank[0].rd_q;
    assign rd_bias  = g_bank[1].rd_q;

endmodule

// File: rtl/cnn_bn_relu_stream.sv
// Per-channel batch-norm (scale, bias) with optional ReLU on a channel-planar
// pixel stream. Parameters are loaded as scale/bias pairs per channel, then
// pixels flow through a fixed three-stage pipeline with no backpressure.
module cnn_bn_relu_stream
    import cnn_bn_relu_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAC_BITS       = 8,
    parameter int IMAGE_WIDTH     = 306,
    parameter int IMAGE_HEIGHT    = 306,
    parameter int CHANNEL_NUM_OUT = 1,
    parameter int RELU_EN         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_param_in,
    input  logic [DATA_WIDTH-1:0] param_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  param_loaded,
    output logic                  frame_done,
    output logic                  err_flag
);

    localparam int DW         = DATA_WIDTH;
    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PW         = cnt_width(IMAGE_SIZE);
    localparam int CW         = cnt_width(CHANNEL_NUM_OUT);
    localparam int AW         = cnt_width(2 * CHANNEL_NUM_OUT);
    localparam int SW         = 2 * DW + 2;   // headroom for rounding and bias add

    localparam logic [PW-1:0] PIX_LAST  = PW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(CHANNEL_NUM_OUT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(2 * CHANNEL_NUM_OUT - 1);
    localparam int            RND_INT   = (FRAC_BITS > 0) ? 2 ** (FRAC_BITS - 1) : 0;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    // Control state
    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] wr_addr_reg, wr_addr_next;
    logic [PW-1:0] pix_cnt_reg;
    logic [CW-1:0] ch_cnt_reg;
    logic          err_reg;
    logic          ram_wr_en;
    logic          pix_accept;
    logic          err_set;
    logic          at_boundary;
    logic          pix_last;
    logic          ch_last;

    // Pipeline state
    logic                   v_s1_reg, last_s1_reg;
    logic signed [DW-1:0]   pxl_s1_reg;
    logic                   v_s2_reg, last_s2_reg;
    logic signed [2*DW-1:0] prod_s2_reg;
    logic signed [DW-1:0]   bias_s2_reg;
    logic [DW-1:0]          pxl_out_reg;
    logic                   valid_out_reg;
    logic                   frame_done_reg;

    logic [DW-1:0]          ram_scale, ram_bias;
    logic signed [DW-1:0]   scale_s1;
    logic signed [SW-1:0]   rounded;
    logic signed [SW-1:0]   sum;
    logic [DW-1:0]          result;

    assign at_boundary = (pix_cnt_reg == '0) && (ch_cnt_reg == '0);
    assign pix_last    = (pix_cnt_reg == PIX_LAST);
    assign ch_last     = (ch_cnt_reg == CH_LAST);

    // Next-state, RAM write and pixel-accept decisions; a parameter word at a frame boundary wins over a pixel.
    always_comb begin
        state_next   = state_reg;
        wr_addr_next = wr_addr_reg;
        ram_wr_en    = 1'b0;
        pix_accept   = 1'b0;
        err_set      = 1'b0;
        case (state_reg)
            ST_EMPTY, ST_LOAD: begin
                if (valid_in) begin
                    err_set = 1'b1;
                end
                if (valid_param_in) begin
                    ram_wr_en = 1'b1;
                    if (wr_addr_reg == ADDR_LAST) begin
                        state_next   = ST_RUN;
                        wr_addr_next = '0;
                    end else begin
                        state_next   = ST_LOAD;
                        wr_addr_next = wr_addr_reg + AW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (valid_param_in && at_boundary) begin
                    // Reload starts: this word lands at address 0 (wr_addr_reg is 0 in RUN).
                    ram_wr_en    = 1'b1;
                    wr_addr_next = AW'(1);
                    state_next   = ST_LOAD;
                    if (valid_in) begin
                        err_set = 1'b1;
                    end
                end else begin
                    if (valid_param_in) begin
                        err_set = 1'b1;
                    end
                    pix_accept = valid_in;
                end
            end
            default: begin
                state_next   = ST_EMPTY;
                wr_addr_next = '0;
            end
        endcase
    end

    // FSM, parameter address, sticky error and pixel/channel counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_EMPTY;
            wr_addr_reg <= '0;
            err_reg     <= 1'b0;
            pix_cnt_reg <= '0;
            ch_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            wr_addr_reg <= wr_addr_next;
            err_reg     <= err_reg | err_set;
            if (pix_accept) begin
                if (pix_last) begin
                    pix_cnt_reg <= '0;
                    ch_cnt_reg  <= ch_last ? '0 : ch_cnt_reg + CW'(1);
                end else begin
                    pix_cnt_reg <= pix_cnt_reg + PW'(1);
                end
            end
        end
    end

    cnn_bn_param_ram #(
        .DATA_WIDTH (DW),
        .CH_NUM     (CHANNEL_NUM_OUT)
    ) u_param_ram (
        .clk      (clk),
        .wr_en    (ram_wr_en),
        .wr_addr  (wr_addr_reg),
        .wr_data  (param_in),
        .rd_ch    (ch_cnt_reg),
        .rd_scale (ram_scale),
        .rd_bias  (ram_bias)
    );

    assign scale_s1 = ram_scale;

    // S1: capture the pixel alongside the RAM read of its channel's parameters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_s1_reg    <= 1'b0;
            last_s1_reg <= 1'b0;
            pxl_s1_reg  <= '0;
        end else begin
            v_s1_reg    <= pix_accept;
            last_s1_reg <= pix_accept && pix_last && ch_last;
            pxl_s1_reg  <= pxl_in;
        end
    end

    // S2: full-precision signed product; bias travels alongside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_s2_reg    <= 1'b0;
            last_s2_reg <= 1'b0;
            prod_s2_reg <= '0;
            bias_s2_reg <= '0;
        end else begin
            v_s2_reg    <= v_s1_reg;
            last_s2_reg <= last_s1_reg;
            prod_s2_reg <= pxl_s1_reg * scale_s1;
            bias_s2_reg <= ram_bias;
        end
    end

    // S3 arithmetic: round half up back to the pixel Q format, add bias, saturate, optional ReLU.
    always_comb begin
        rounded = (SW'(prod_s2_reg) + SW'(RND_INT)) >>> FRAC_BITS;
        sum     = rounded + SW'(bias_s2_reg);
        if (sum > SAT_MAX) begin
            result = SAT_MAX[DW-1:0];
        end else if (sum < SAT_MIN) begin
            result = SAT_MIN[DW-1:0];
        end else begin
            result = sum[DW-1:0];
        end
        if ((RELU_EN != 0) && result[DW-1]) begin
            result = '0;
        end
    end

    // S3 register: output word, valid and end-of-frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out_reg    <= '0;
            valid_out_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            valid_out_reg  <= v_s2_reg;
            frame_done_reg <= v_s2_reg && last_s2_reg;
            if (v_s2_reg) begin
                pxl_out_reg <= result;
            end
        end
    end

    assign pxl_out      = pxl_out_reg;
    assign valid_out    = valid_out_reg;
    assign frame_done   = frame_done_reg;
    assign err_flag     = err_reg;
    assign param_loaded = (state_reg == ST_RUN);

endmodule

// File: tb/tb_cnn_bn_relu_stream.sv
// Directed bench for cnn_bn_relu_stream: one instance with ReLU, one without,
// fed identical stimulus (2x2 image, 2 channels, Q8.8).
module tb_cnn_bn_relu_stream;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_param_in;
    logic [DW-1:0] param_in;
    logic          valid_in;
    logic [DW-1:0] pxl_in;

    logic [DW-1:0] pxl_out_r, pxl_out_n;
    logic          valid_out_r, valid_out_n;
    logic          param_loaded_r, param_loaded_n;
    logic          frame_done_r, frame_done_n;
    logic          err_flag_r, err_flag_n;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] n;
        logic          fd;
    } out_t;

    out_t out_q[$];

    always #5 clk = ~clk;

    cnn_bn_relu_stream #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_OUT(2), .RELU_EN(1)
    ) dut_r (
        .clk(clk), .reset(reset), .valid_param_in(valid_param_in), .param_in(param_in),
        .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out_r), .valid_out(valid_out_r),
        .param_loaded(param_loaded_r), .frame_done(frame_done_r), .err_flag(err_flag_r)
    );

    cnn_bn_relu_stream #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_OUT(2), .RELU_EN(0)
    ) dut_n (
        .clk(clk), .reset(reset), .valid_param_in(valid_param_in), .param_in(param_in),
        .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out_n), .valid_out(valid_out_n),
        .param_loaded(param_loaded_n), .frame_done(frame_done_n), .err_flag(err_flag_n)
    );

    // Record every output beat of both instances on the falling edge.
    always @(negedge clk) begin
        if (valid_out_r || valid_out_n) begin
            out_q.push_back('{r: pxl_out_r, n: pxl_out_n, fd: frame_done_r || frame_done_n});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] w);
        valid_param_in = 1'b1;
        param_in       = w;
        tick();
        valid_param_in = 1'b0;
    endtask

    task automatic send_pix(input logic [DW-1:0] p);
        valid_in = 1'b1;
        pxl_in   = p;
        tick();
        valid_in = 1'b0;
    endtask

    logic [DW-1:0] exp_a_r [8] = '{16'h0280, 16'h0000, 16'h7FFF, 16'h0000,
                                   16'h0100, 16'h0100, 16'h0100, 16'h0100};
    logic [DW-1:0] exp_a_n [8] = '{16'h0280, 16'hFE80, 16'h7FFF, 16'h8000,
                                   16'h0100, 16'h0100, 16'h0100, 16'h0100};
    logic [DW-1:0] exp_b   [8] = '{16'h0040, 16'h0040, 16'h0040, 16'h0040,
                                   16'h0140, 16'h0140, 16'h0140, 16'h0140};

    initial begin
        reset          = 1'b0;
        valid_param_in = 1'b0;
        param_in       = '0;
        valid_in       = 1'b0;
        pxl_in         = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_pxl_out", pxl_out_r, 0);
        check("rst_valid_out", valid_out_r, 0);
        check("rst_param_loaded", param_loaded_r, 0);
        check("rst_frame_done", frame_done_r, 0);
        check("rst_err_flag", err_flag_r, 0);
        reset = 1'b1;
        tick();

        // Pixel before any parameters: dropped, error raised
        send_pix(16'h1234);
        repeat (4) tick();
        check("preload_no_output", out_q.size(), 0);
        check("preload_err", err_flag_r, 1);
        check("preload_param_loaded", param_loaded_r, 0);

        // Asynchronous reset clears the sticky error without a clock edge
        reset = 1'b0;
        #1;
        check("async_rst_err", err_flag_r, 0);
        reset = 1'b1;
        tick();

        // Load ch0 {2.0, 0.5}, ch1 {1.0, 0}
        load_word(16'h0200);
        load_word(16'h0080);
        load_word(16'h0100);
        check("load3_param_loaded", param_loaded_r, 0);
        load_word(16'h0000);
        check("load4_param_loaded", param_loaded_r, 1);
        check("load_err", err_flag_r, 0);
        out_q.delete();

        // Exact three-cycle latency: 1.0*2.0+0.5 = 2.5
        send_pix(16'h0100);
        check("lat_edge1_valid", valid_out_r, 0);
        tick();
        check("lat_edge2_valid", valid_out_r, 0);
        tick();
        check("lat_edge3_valid", valid_out_r, 1);
        check("lat_pxl_relu", pxl_out_r, 16'h0280);
        check("lat_pxl_norelu", pxl_out_n, 16'h0280);

        // Rest of the frame: negative, positive and negative saturation, then ch1
        send_pix(16'hFF00);
        send_pix(16'h7000);
        send_pix(16'h8000);
        send_pix(16'h0100);
        // Parameter word mid-frame: ignored, error raised, still running
        load_word(16'h0500);
        check("midframe_param_loaded", param_loaded_r, 1);
        check("midframe_err", err_flag_r, 1);
        send_pix(16'h0100);
        send_pix(16'h0100);
        send_pix(16'h0100);
        repeat (5) tick();
        check("frameA_count", out_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < out_q.size()) begin
                check($sformatf("frameA_relu[%0d]", i), out_q[i].r, exp_a_r[i]);
                check($sformatf("frameA_norelu[%0d]", i), out_q[i].n, exp_a_n[i]);
                check($sformatf("frameA_fd[%0d]", i), out_q[i].fd, (i == 7) ? 1 : 0);
            end
        end
        out_q.delete();

        // Reload at the frame boundary; the concurrent pixel must be dropped
        valid_param_in = 1'b1;
        param_in       = 16'h0100;
        valid_in       = 1'b1;
        pxl_in         = 16'h7000;
        tick();
        valid_param_in = 1'b0;
        valid_in       = 1'b0;
        check("reload_param_loaded_drop", param_loaded_r, 0);
        load_word(16'h0000);
        load_word(16'h0100);
        load_word(16'h0100);
        check("reload_param_loaded", param_loaded_r, 1);

        // Frame B: eight 0.25 pixels with random gaps
        for (int i = 0; i < 8; i++) begin
            send_pix(16'h0040);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (5) tick();
        check("frameB_count", out_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < out_q.size()) begin
                check($sformatf("frameB_relu[%0d]", i), out_q[i].r, exp_b[i]);
                check($sformatf("frameB_norelu[%0d]", i), out_q[i].n, exp_b[i]);
                check($sformatf("frameB_fd[%0d]", i), out_q[i].fd, (i == 7) ? 1 : 0);
            end
        end
        check("frameB_err_sticky", err_flag_r, 1);

        // Reset after five pixels of a frame
        for (int i = 0; i < 5; i++) begin
            send_pix(16'h0100);
        end
        check("prereset_valid", valid_out_r, 1);
        reset = 1'b0;
        #1;
        check("midrst_valid_out", valid_out_r, 0);
        check("midrst_pxl_out", pxl_out_r, 0);
        check("midrst_valid_out_n", valid_out_n, 0);
        check("midrst_param_loaded", param_loaded_r, 0);
        check("midrst_frame_done", frame_done_r, 0);
        check("midrst_err", err_flag_r, 0);
        reset = 1'b1;
        tick();

        // Reload and rerun the first case
        load_word(16'h0200);
        load_word(16'h0080);
        load_word(16'h0100);
        load_word(16'h0000);
        check("rerun_param_loaded", param_loaded_r, 1);
        send_pix(16'h0100);
        tick();
        tick();
        check("rerun_valid", valid_out_r, 1);
        check("rerun_pxl", pxl_out_r, 16'h0280);
        check("rerun_err", err_flag_r, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
